// File: rtl/spi_slave_stream.sv
// SPI mode-0 slave clocked entirely by the system clock.
// sck, cs_n and mosi are oversampled through synchronisers; received words
// leave on a valid/ready stream and transmit words arrive on another one.
// Overrun, underrun and truncated-frame events are reported as single pulses.
module spi_slave_stream #(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter logic [WIDTH-1:0]  IDLE_WORD   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             overrun,
    output logic             underrun,
    output logic             frame_err
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Synchroniser chains: index 0 samples the pin, index SYNC_STAGES-1 is the stable copy.
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_n_prev_q, cs_n_prev_d;
    // Marks how far valid pin samples have travelled down the chains since reset.
    logic [SYNC_STAGES:0]   fill_q, fill_d;
    // Set once cs_n has genuinely been seen high; a frame already running at
    // reset release must not be joined half-way through.
    logic                   armed_q, armed_d;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   miso_q, miso_d;
    logic                   busy_q, busy_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   overrun_q, overrun_d;
    logic                   underrun_q, underrun_d;
    logic                   frame_err_q, frame_err_d;

    logic                   sck_s, cs_n_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;
    logic [WIDTH-1:0]       rx_word, tx_shifted;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_n_s & cs_n_prev_q & armed_q;
    assign cs_rise  = cs_n_s & ~cs_n_prev_q;

    // Word as it stands after shifting in the current mosi bit, and the
    // transmit register advanced by one bit toward the output end.
    assign rx_word    = MSB_FIRST ? {rx_shift_q[WIDTH-2:0], mosi_s}
                                  : {mosi_s, rx_shift_q[WIDTH-1:1]};
    assign tx_shifted = MSB_FIRST ? {tx_shift_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, tx_shift_q[WIDTH-1:1]};

    // Advance the synchroniser chains and the post-reset fill marker.
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_s;
        cs_n_prev_d = cs_n_s;
        fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
        armed_d     = armed_q | (fill_q[SYNC_STAGES] & cs_n_s & cs_n_prev_q);
    end

    // Frame state machine: next state, shift registers, stream handshakes and event pulses.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        tx_ready_d  = 1'b0;
        overrun_d   = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    if (tx_valid) begin
                        tx_shift_d = tx_data;
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_shift_d = IDLE_WORD;
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                // cs_n rising takes priority over any sck edge seen alongside it.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    frame_err_d = (cnt_q != '0);
                end else if (sck_rise) begin
                    rx_shift_d = rx_word;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (cnt_q != '0) begin
                        tx_shift_d = tx_shifted;
                    end else if (tx_valid) begin
                        tx_shift_d = tx_data;
                        tx_ready_d = 1'b1;
                    end else begin
                        tx_shift_d = IDLE_WORD;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ACTIVE);
        if (state_d == ST_ACTIVE) begin
            miso_d = MSB_FIRST ? tx_shift_d[WIDTH-1] : tx_shift_d[0];
        end else begin
            miso_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: cs_n synchroniser flops reset to 1 (deselected) so that
            // reset itself never looks like the start of a frame.
            sck_sync_q  <= '0;
            cs_n_sync_q <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_n_prev_q <= 1'b1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            sck_sync_q  <= sck_sync_d;
            cs_n_sync_q <= cs_n_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_n_prev_q <= cs_n_prev_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            tx_ready_q  <= tx_ready_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign busy      = busy_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_ready  = tx_ready_q;
    assign overrun   = overrun_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule
